fusion_sequencer: RTL and testbench
===================================

Name: fusion_sequencer

Overview:
- Temporal sequencer for one fusion subunit.
- Accepts a dot-product command (activation/weight precision, signedness, vector length).
- Steps the subunit through every 4-bit-slice pass of every element, driving the subunit's shift and sign controls.
- Accumulates the returned 16-bit subunit sums into a wide accumulator and returns the result over a valid/ready handshake. Sits between the layer controller and the fusion subunit/operand buffers.

Parameters:
- ACC_W, 32, accumulator/result width (≥ 20).
- LEN_W, 8, width of the element-count field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command (IDLE only).
- cmd_abits  in  2  activation precision: 00=2b, 01=4b, 10=8b, 11 treated as 8b.
- cmd_wbits  in  2  weight precision, same encoding.
- cmd_sign  in  1  signed operands.
- cmd_len  in  LEN_W  number of elements; 0 is legal.
- op_valid  in  1  operand slices for the current pass are presented to the subunit.
- fu_en  out  1  pass active; operand buffers fetch slice (fu_elem, fu_aslice, fu_wslice).
- fu_elem  out  LEN_W  current element index.
- fu_aslice  out  1  activation slice index (0=low nibble).
- fu_wslice  out  1  weight slice index.
- fu_shift  out  4  subunit shift control.
- fu_sign  out  1  subunit sign control.
- fu_sum  in  16  combinational subunit result for the current pass.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  ACC_W  accumulated dot product.

Behaviour:
- Reset (async, rst_n=0), registered state:
  - state=IDLE, acc=0, counters=0.
  - Outputs: res_valid=0, res_data=0, fu_en=0, fu_shift=0, fu_sign=0, fu_elem=0, fu_aslice=0, fu_wslice=0; cmd_ready=1 after reset.
- Slices per operand: na = 2 if abits is 8b/11, else 1; nw likewise. Passes per element P = na*nw (1, 2 or 4).
- Per-pass controls:
  - fu_shift = 4*(aslice+wslice).
  - fu_sign = cmd_sign AND (aslice==na-1 OR wslice==nw-1), i.e. only passes holding an MSB slice are signed.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch the command, clear acc, zero counters.
  - Go to RUN, or to DONE directly if cmd_len=0.
- RUN:
  - fu_en=1. A pass completes in a cycle with op_valid=1.
  - On completion, acc += fu_sum, sign-extended to ACC_W if cmd_sign else zero-extended. Addition wraps modulo 2^ACC_W.
  - Iteration order: aslice innermost, then wslice, then fu_elem.
  - op_valid=0 stalls: counters, acc and outputs hold.
  - After the last pass of element len-1, go to DONE.
- DONE:
  - res_valid=1, res_data=acc; both held stable until res_ready=1.
  - Handshake cycle returns to IDLE; cmd_ready is 1 from the following cycle. No new command is accepted in the handshake cycle.
- Timing (op_valid constantly 1): command accepted at cycle T; passes occupy T+1..T+len*P; res_valid rises at T+len*P+1. len=0 gives res_valid at T+1 with res_data=0.
- Reset mid-RUN or mid-DONE aborts immediately; the pending result is lost; no partial res_valid.
- Command inputs are ignored outside IDLE.

Decomposition:
- Shared package fusion_pkg holds:
  - precision encodings PREC_2B/PREC_4B/PREC_8B;
  - FSM state typedef;
  - SLICE_BITS=4 constant;
  - function computing na/nw from a precision code.
- Natural sub-module: fusion_pass_counter (aslice/wslice/elem nested counter with last-pass flag). Accumulator and FSM stay in the top.

Test Plan:
- 4b unsigned, len=3, fu_sum=5,6,7, op_valid=1 -> one pass per element, fu_shift=0, fu_sign=0; res_valid at T+4, res_data=18.
- 8b×8b signed, len=1, fu_sum=16'h0010,16'hFFF0,16'h0020,16'hFFFF:
  - (a,w) order (0,0),(1,0),(0,1),(1,1); fu_shift=0,4,4,8; fu_sign=0,1,1,1.
  - res_data=31.
- 8b act × 2b wgt unsigned, len=2, fu_sum=16'hFFFF each -> P=2, shifts 0,4; res_data=4×65535=262140.
- op_valid toggled 1,0,0,1 on 4b len=2 -> counters hold during stall; res_valid at T+5 with correct sum.
- len=0 -> res_valid at T+1, res_data=0. res_ready held low 5 cycles -> res_valid/res_data stable, cmd_ready=0 throughout.
- rst_n pulsed low mid-RUN (element 1 of 3) -> all outputs return to reset values asynchronously. A fresh command afterwards yields a correct, uncontaminated result.

Source files
------------

// File: rtl/fusion_pkg.sv
// fusion_pkg: shared precision codes, FSM state type and slice-count helper
package fusion_pkg;
  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;
  localparam int SLICE_BITS = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  // 8b operands (and the reserved 11 code) split into two nibble slices.
  function automatic logic [1:0] num_slices(input logic [1:0] prec);
    return (prec == PREC_8B || prec == 2'b11) ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/fusion_pass_counter.sv
// fusion_pass_counter: nested aslice/wslice/element pass counter with last-pass flag
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr_i               zero all counters
//   step_i              advance by one pass
//   a_two_i, w_two_i    operand uses two slices (last slice index is 1)
//   len_i               element count (>= 1 while stepping)
//   aslice_o, wslice_o  current slice indices
//   elem_o              current element index
//   last_o              current pass is the final one of the command
module fusion_pass_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             a_two_i,
  input  logic             w_two_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             aslice_o,
  output logic             wslice_o,
  output logic [LEN_W-1:0] elem_o,
  output logic             last_o
);
  logic a_q, a_d, w_q, w_d;
  logic [LEN_W-1:0] e_q, e_d;
  logic a_end, w_end, wrap;
  always_comb begin
    a_end  = a_q == a_two_i;
    w_end  = w_q == w_two_i;
    last_o = a_end & w_end & (e_q == len_i - LEN_W'(1));
    // Final pass wraps everything to zero so the slice/element outputs idle at 0.
    wrap   = clr_i | (step_i & last_o);
    a_d    = wrap ? 1'b0 : step_i ? !a_end : a_q;
    w_d    = wrap ? 1'b0 : (step_i & a_end) ? !w_end : w_q;
    e_d    = wrap ? '0 : (step_i & a_end & w_end) ? e_q + LEN_W'(1) : e_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 1'b0;
      w_q <= 1'b0;
      e_q <= '0;
    end else begin
      a_q <= a_d;
      w_q <= w_d;
      e_q <= e_d;
    end
  end
  assign aslice_o = a_q;
  assign wslice_o = w_q;
  assign elem_o   = e_q;
endmodule

// File: rtl/fusion_sequencer.sv
// fusion_sequencer: steps a fusion subunit through all slice passes of a dot product and accumulates the result
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cmd_valid/cmd_ready                 command handshake (accepted in IDLE only)
//   cmd_abits, cmd_wbits, cmd_sign      operand precisions and signedness
//   cmd_len                             element count (0 legal)
//   op_valid                            operands for the current pass are ready
//   fu_en, fu_elem, fu_aslice, fu_wslice  pass fetch controls
//   fu_shift, fu_sign                   subunit controls
//   fu_sum                              subunit result for the current pass
//   res_valid/res_ready, res_data       result handshake
module fusion_sequencer
  import fusion_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_abits,
  input  logic [1:0]       cmd_wbits,
  input  logic             cmd_sign,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             fu_en,
  output logic [LEN_W-1:0] fu_elem,
  output logic             fu_aslice,
  output logic             fu_wslice,
  output logic [3:0]       fu_shift,
  output logic             fu_sign,
  input  logic [15:0]      fu_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);
  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_ext;
  logic [LEN_W-1:0] len_q;
  logic a_two_q, w_two_q, sign_q;
  logic accept, step, last;
  fusion_pass_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .step_i   (step),
    .a_two_i  (a_two_q),
    .w_two_i  (w_two_q),
    .len_i    (len_q),
    .aslice_o (fu_aslice),
    .wslice_o (fu_wslice),
    .elem_o   (fu_elem),
    .last_o   (last)
  );
  always_comb begin
    accept  = (state_q == S_IDLE) & cmd_valid;
    step    = (state_q == S_RUN) & op_valid;
    sum_ext = sign_q ? {{(ACC_W-16){fu_sum[15]}}, fu_sum} : {{(ACC_W-16){1'b0}}, fu_sum};
    acc_d   = accept ? '0 : step ? acc_q + sum_ext : acc_q;
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = cmd_valid ? ((cmd_len == '0) ? S_DONE : S_RUN) : S_IDLE;
      S_RUN:   state_d = (op_valid & last) ? S_DONE : S_RUN;
      S_DONE:  state_d = res_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      a_two_q <= 1'b0;
      w_two_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        len_q   <= cmd_len;
        a_two_q <= num_slices(cmd_abits) == 2'd2;
        w_two_q <= num_slices(cmd_wbits) == 2'd2;
        sign_q  <= cmd_sign;
      end
    end
  end
  assign cmd_ready = state_q == S_IDLE;
  assign fu_en     = state_q == S_RUN;
  // Shift is 4*(aslice+wslice); with 1-bit slice indices the sum is {a&w, a^w}.
  assign fu_shift  = {fu_aslice & fu_wslice, fu_aslice ^ fu_wslice, 2'b00};
  // Only passes that contain at least one MSB slice are treated as signed.
  assign fu_sign   = fu_en & sign_q & ((fu_aslice == a_two_q) | (fu_wslice == w_two_q));
  assign res_valid = state_q == S_DONE;
  assign res_data  = acc_q;
endmodule

// File: tb/tb_fusion_sequencer.sv
// tb_fusion_sequencer: directed self-checking bench for fusion_sequencer
module tb_fusion_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_abits = 2'b00;
  logic [1:0]  cmd_wbits = 2'b00;
  logic        cmd_sign = 1'b0;
  logic [7:0]  cmd_len = 8'd0;
  logic        op_valid = 1'b0;
  logic        fu_en;
  logic [7:0]  fu_elem;
  logic        fu_aslice;
  logic        fu_wslice;
  logic [3:0]  fu_shift;
  logic        fu_sign;
  logic [15:0] fu_sum = 16'h0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  int checks = 0;
  int failures = 0;
  logic [16:0] ctl;

  always #5 clk = ~clk;

  fusion_sequencer #(.ACC_W(32), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_abits (cmd_abits),
    .cmd_wbits (cmd_wbits),
    .cmd_sign  (cmd_sign),
    .cmd_len   (cmd_len),
    .op_valid  (op_valid),
    .fu_en     (fu_en),
    .fu_elem   (fu_elem),
    .fu_aslice (fu_aslice),
    .fu_wslice (fu_wslice),
    .fu_shift  (fu_shift),
    .fu_sign   (fu_sign),
    .fu_sum    (fu_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // Packed control snapshot: {en, elem, aslice, wslice, shift, sign, res_valid}
  assign ctl = {fu_en, fu_elem, fu_aslice, fu_wslice, fu_shift, fu_sign, res_valid};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] a, input logic [1:0] w, input logic s, input logic [7:0] l);
    cmd_abits = a;
    cmd_wbits = w;
    cmd_sign  = s;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({cmd_ready, ctl} !== {1'b1, 17'h0}) begin
      failures++;
      $display("FAIL reset_ctl got=%h exp=%h", {cmd_ready, ctl}, {1'b1, 17'h0});
    end
    checks++;
    if (res_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%0d exp=0", res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_4b;
    logic [15:0] sums [3] = '{16'd5, 16'd6, 16'd7};
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL u4_ready got=%b exp=1", cmd_ready);
    end
    issue(2'b01, 2'b01, 1'b0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      fu_sum = sums[i];
      op_valid = 1'b1;
      checks++;
      if (ctl !== {1'b1, 8'(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL u4_pass%0d got=%h exp=%h", i, ctl, {1'b1, 8'(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if ({res_valid, cmd_ready, res_data} !== {1'b1, 1'b0, 32'd18}) begin
      failures++;
      $display("FAIL u4_result got v=%b rdy=%b d=%0d exp v=1 rdy=0 d=18", res_valid, cmd_ready, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL u4_handshake got v=%b rdy=%b exp v=0 rdy=1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_signed_8x8;
    logic [15:0] sums [4] = '{16'h0010, 16'hFFF0, 16'h0020, 16'hFFFF};
    logic        ea [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        ew [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  es [4] = '{4'd0, 4'd4, 4'd4, 4'd8};
    logic        eg [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    issue(2'b10, 2'b10, 1'b1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      fu_sum = sums[i];
      op_valid = 1'b1;
      checks++;
      if (ctl !== {1'b1, 8'd0, ea[i], ew[i], es[i], eg[i], 1'b0}) begin
        failures++;
        $display("FAIL s88_pass%0d got=%h exp=%h", i, ctl, {1'b1, 8'd0, ea[i], ew[i], es[i], eg[i], 1'b0});
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'd31}) begin
      failures++;
      $display("FAIL s88_result got v=%b d=%0d exp v=1 d=31", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_mixed_8x2;
    issue(2'b10, 2'b00, 1'b0, 8'd2);
    for (int i = 0; i < 4; i++) begin
      fu_sum = 16'hFFFF;
      op_valid = 1'b1;
      checks++;
      if (ctl !== {1'b1, 8'(i / 2), 1'(i % 2), 1'b0, 4'((i % 2) * 4), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL m82_pass%0d got=%h exp=%h", i, ctl, {1'b1, 8'(i / 2), 1'(i % 2), 1'b0, 4'((i % 2) * 4), 1'b0, 1'b0});
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'd262140}) begin
      failures++;
      $display("FAIL m82_result got v=%b d=%0d exp v=1 d=262140", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_stall;
    logic        ov [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] sums [4] = '{16'd5, 16'd100, 16'd200, 16'd9};
    logic [7:0]  ee [4] = '{8'd0, 8'd1, 8'd1, 8'd1};
    issue(2'b01, 2'b01, 1'b0, 8'd2);
    for (int i = 0; i < 4; i++) begin
      fu_sum = sums[i];
      op_valid = ov[i];
      checks++;
      if (ctl !== {1'b1, ee[i], 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall_cyc%0d got=%h exp=%h", i, ctl, {1'b1, ee[i], 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'd14}) begin
      failures++;
      $display("FAIL stall_result got v=%b d=%0d exp v=1 d=14", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_len0_hold;
    issue(2'b01, 2'b01, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      res_ready = 1'b0;
      cmd_len   = 8'd4;
      cmd_valid = 1'b1;
      checks++;
      if ({res_valid, cmd_ready, fu_en, res_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        failures++;
        $display("FAIL len0_hold%0d got v=%b rdy=%b en=%b d=%0d exp v=1 rdy=0 en=0 d=0", i, res_valid, cmd_ready, fu_en, res_data);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready, fu_en} !== 3'b010) begin
      failures++;
      $display("FAIL len0_handshake got v=%b rdy=%b en=%b exp v=0 rdy=1 en=0", res_valid, cmd_ready, fu_en);
    end
  endtask

  task automatic test_mid_reset;
    logic [15:0] sums [2] = '{16'd3, 16'd4};
    issue(2'b01, 2'b01, 1'b0, 8'd3);
    fu_sum = 16'd50;
    op_valid = 1'b1;
    tick();
    checks++;
    if (fu_elem !== 8'd1) begin
      failures++;
      $display("FAIL mrst_elem got=%0d exp=1", fu_elem);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, ctl, res_data} !== {1'b1, 17'h0, 32'd0}) begin
      failures++;
      $display("FAIL mrst_async got rdy=%b ctl=%h d=%0d exp rdy=1 ctl=0 d=0", cmd_ready, ctl, res_data);
    end
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(2'b01, 2'b01, 1'b0, 8'd2);
    for (int i = 0; i < 2; i++) begin
      fu_sum = sums[i];
      op_valid = 1'b1;
      checks++;
      if (ctl !== {1'b1, 8'(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL mrst_pass%0d got=%h exp=%h", i, ctl, {1'b1, 8'(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'd7}) begin
      failures++;
      $display("FAIL mrst_result got v=%b d=%0d exp v=1 d=7", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_4b();
    test_signed_8x8();
    test_mixed_8x2();
    test_stall();
    test_len0_hold();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
